spi_reg_target: RTL and testbench
=================================

Name: spi_reg_target

Overview:
- SPI peripheral-side (target) register-access engine. It is the far end of the on-board SPI master driver.
- Oversamples the SPI pins on the fabric clock and decodes command and data frames.
- Issues one-cycle read/write strobes to a register file and shifts read data back on MISO.
- Sits between the board SPI pins and the control register bank.

Parameters:
- REG_WIDTH, 8, data bits per register, equal to bits per data frame.
- ADDR_WIDTH, 7, address bits; command frame length is ADDR_WIDTH+1.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  input  1  fabric clock; must run at ≥8× spi_sclk.
- rstn  input  1  asynchronous active-low reset.
- spi_sclk  input  1  SPI clock from master, async; mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  input  1  chip select, active low, async.
- spi_mosi  input  1  serial data in, MSB first.
- spi_miso  output  1  serial data out, MSB first.
- spi_miso_oe  output  1  MISO output enable, high only during read data frames.
- reg_addr  output  ADDR_WIDTH  current register address.
- reg_wdata  output  REG_WIDTH  write data; valid while reg_we is high.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read request.
- reg_rdata  input  REG_WIDTH  read data; must be valid the cycle after reg_re.
- busy  output  1  high while cs_n is low (synchronized).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values: all outputs 0 (spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0). State=IDLE, bit counter=0, synchronizers cleared.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detect on the synchronized sclk gives rise/fall pulses, one clk cycle each. mosi is sampled on the rise pulse.
- Frame format:
  - Command frame, ADDR_WIDTH+1 bits: {is_write, addr}.
  - Then one or more REG_WIDTH-bit data frames.
  - Burst: each further data frame targets addr+1, wrapping modulo 2^ADDR_WIDTH (127 -> 0 by default).
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD when synchronized cs_n goes low; counter cleared.
- CMD: shift in one bit per rise.
  - After the (ADDR_WIDTH+1)th rise, latch reg_addr and is_write.
  - is_write=1 -> WDATA.
  - is_write=0 -> pulse reg_re on the following cycle. Capture reg_rdata into the TX shifter the cycle after reg_re, then go to RDATA.
- WDATA: shift in one bit per rise.
  - After the REG_WIDTHth rise: reg_wdata = shifted byte and reg_we=1 for exactly one cycle, with reg_addr stable.
  - Address increments the cycle after reg_we. Counter clears; stay in WDATA.
- RDATA:
  - spi_miso_oe=1 and spi_miso=TX[MSB] from TX-shifter load.
  - Each fall shifts TX left, so the next bit appears before the next rise. The fall after the final command rise is the one that loads bit 7; the shifter is already loaded by then because clk ≥ 8× sclk.
  - After the REG_WIDTHth rise: increment reg_addr, pulse reg_re, reload TX the next cycle. Stay in RDATA.
- cs_n deassert, any state:
  - Return to IDLE the cycle after synchronized cs_n goes high; spi_miso_oe=0, spi_miso=0.
  - A partial frame is discarded: no reg_we, no address change.
  - A reg_re already issued is harmless.
- A rise and a cs_n rise in the same cycle: the cs_n rise wins and the bit is dropped.
- sclk edges while cs_n is high are ignored.
- busy = inverted synchronized cs_n, registered.
- Async rstn mid-frame: immediate return to reset values. The frame resumes only after cs_n goes high, then low again. Until then, stay in IDLE and ignore edges even if cs_n is already low at reset release.

Test Plan:
- Write 0x05 <- 0xA5 (command 0x85, data 0xA5): one reg_we with reg_addr=0x05, reg_wdata=0xA5; busy high for the frame; spi_miso_oe stays 0.
- Read 0x12 (command 0x12), reg_rdata model returns 0x3C: reg_re once with reg_addr=0x12; master samples 0x3C on MISO; spi_miso_oe high only during the data frame.
- Burst write from 0x7F with data 0x11,0x22: reg_we at addr 0x7F with 0x11, then at addr 0x00 with 0x22 (wrap).
- Burst read from 0x20, model rdata=addr^0xFF, two frames: MISO returns 0xDF then 0xDE; reg_re pulses at 0x20, 0x21, 0x22 (third is a harmless prefetch).
- Write command 0x83 then cs_n raised after 4 data bits: no reg_we; next full write to 0x03 of 0x77 lands correctly.
- rstn asserted mid read data frame with cs_n held low: outputs 0 immediately; after release, no strobes until cs_n toggles high then low; a following write to 0x01 of 0x5A succeeds.

Source files
------------

// File: rtl/spi_reg_target.sv
// SPI mode-0 target that turns command/data frames into register-file strobes.
// Latency: pins are seen SYNC_STAGES+1 clk after they move; reg_re follows the last command bit by one cycle.
// Backpressure: none; the master paces everything, and clk must be at least 8x sclk so read data is loaded in time.
//
// Ports:
//   clk, rstn                 fabric clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi        asynchronous SPI pins from the board master
//   spi_miso, spi_miso_oe     serial read data and its output enable
//   reg_addr/wdata/we/re      register-file access strobes
//   reg_rdata                 read data, valid the cycle after reg_re
//   busy                      synchronized chip select, active high
module spi_reg_target #(
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [REG_WIDTH-1:0]  reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [REG_WIDTH-1:0]  reg_rdata,
  output logic                  busy
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int MAX_BITS = (CMD_BITS > REG_WIDTH) ? CMD_BITS : REG_WIDTH;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_BITS - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(REG_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  // Pin synchronizers
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk;
  logic w_cs;
  logic w_mosi;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;

  // Datapath / control state
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_cmd_sr;
  logic [REG_WIDTH-2:0]  r_wsr;
  logic [REG_WIDTH-1:0]  r_tx;
  logic                  r_ld_pend;
  logic                  r_oe;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic                  r_we;
  logic                  r_re;
  logic                  r_busy;

  logic [CMD_BITS-1:0]   w_cmd_next;
  logic [REG_WIDTH-1:0]  w_wdat_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  // The cs delay flop resets low, so a select already low at reset release
  // never looks like a falling edge: a fresh high->low is required.
  assign w_cs_fall = r_cs_d & ~w_cs;

  assign w_cmd_next  = {r_cmd_sr, w_mosi};
  assign w_wdat_next = {r_wsr, w_mosi};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cmd_sr  <= '0;
      r_wsr     <= '0;
      r_tx      <= '0;
      r_ld_pend <= 1'b0;
      r_oe      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_busy    <= ~w_cs;
      // Read data arrives the cycle after reg_re; load it one cycle later.
      r_ld_pend <= r_re;
      // Post-write address advance, one cycle after the strobe.
      if (r_we) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end

      if (w_cs) begin
        // Deselect wins over any coincident sclk edge; partial frames vanish.
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_tx      <= '0;
        r_oe      <= 1'b0;
        r_ld_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
            end
          end

          S_CMD: begin
            if (w_rise) begin
              r_cmd_sr <= w_cmd_next[ADDR_WIDTH-1:0];
              if (r_cnt == CMD_LAST) begin
                r_cnt  <= '0;
                r_addr <= w_cmd_next[ADDR_WIDTH-1:0];
                if (w_cmd_next[ADDR_WIDTH]) begin
                  r_state <= S_WDATA;
                end else begin
                  r_re    <= 1'b1;
                  r_state <= S_RDATA;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end

          S_WDATA: begin
            if (w_rise) begin
              r_wsr <= w_wdat_next[REG_WIDTH-2:0];
              if (r_cnt == DAT_LAST) begin
                r_cnt   <= '0;
                r_wdata <= w_wdat_next;
                r_we    <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end

          S_RDATA: begin
            if (r_ld_pend) begin
              r_tx <= reg_rdata;
              r_oe <= 1'b1;
            end else if (w_fall && (r_cnt != '0)) begin
              // The fall that precedes a frame's first rise only presents
              // the freshly loaded MSB, so it must not shift.
              r_tx <= {r_tx[REG_WIDTH-2:0], 1'b0};
            end
            if (w_rise) begin
              if (r_cnt == DAT_LAST) begin
                r_cnt  <= '0;
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_re   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = r_tx[REG_WIDTH-1];
  assign spi_miso_oe = r_oe;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_we      = r_we;
  assign reg_re      = r_re;
  assign busy        = r_busy;

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: bit-banged mode-0 master, register-file model and
// transaction-level expectations (address sequence, data bytes, strobe counts).
module tb_spi_reg_target;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic       clk;
  logic       rstn;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  spi_reg_target dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [128];
  logic [7:0] tx_dat [4];

  logic [6:0] we_a_q [$];
  logic [7:0] we_d_q [$];
  logic [6:0] re_a_q [$];

  bit         rd_pend = 1'b0;
  logic [7:0] rd_stash;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Register-file model: synchronous read, data valid only in the cycle
  // after reg_re; random garbage otherwise. Also logs every strobe.
  always @(negedge clk) begin
    if (rd_pend) begin
      reg_rdata = rd_stash;
      rd_pend   = 1'b0;
    end else begin
      reg_rdata = 8'($urandom);
    end
    if (reg_re) begin
      rd_pend  = 1'b1;
      rd_stash = mem[reg_addr];
      re_a_q.push_back(reg_addr);
    end
    if (reg_we) begin
      we_a_q.push_back(reg_addr);
      we_d_q.push_back(reg_wdata);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    we_a_q.delete();
    we_d_q.delete();
    re_a_q.delete();
  endtask

  // Shift nb bits MSB-first; MISO is sampled just before each rising edge.
  task automatic spi_shift(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                           output bit oe_any, output bit oe_all, output bit busy_all);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    busy_all = 1'b1;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = tx[7-i];
      wait_cyc(HALF);
      rx       = {rx[6:0], spi_miso};
      oe_any   = oe_any | spi_miso_oe;
      oe_all   = oe_all & spi_miso_oe;
      busy_all = busy_all & busy;
      spi_sclk = 1'b1;
      wait_cyc(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  // One complete transaction of n data frames; data for writes from tx_dat.
  task automatic do_xfer(input bit wr, input logic [6:0] a, input int n, input string tag);
    logic [7:0] rx;
    logic [6:0] ea;
    bit oe_any, oe_all, b_all;
    clear_logs();
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    spi_shift({wr, a}, 8, rx, oe_any, oe_all, b_all);
    check_eq({tag, "_cmd_oe"}, 32'(oe_any), 32'd0);
    check_eq({tag, "_cmd_busy"}, 32'(b_all), 32'd1);
    for (int i = 0; i < n; i++) begin
      ea = 7'((int'(a) + i) % 128);
      spi_shift(wr ? tx_dat[i] : 8'($urandom), 8, rx, oe_any, oe_all, b_all);
      if (wr) begin
        check_eq($sformatf("%s_wr_oe%0d", tag, i), 32'(oe_any), 32'd0);
      end else begin
        check_eq($sformatf("%s_rd_miso%0d", tag, i), 32'(rx), 32'(mem[ea]));
        check_eq($sformatf("%s_rd_oe%0d", tag, i), 32'(oe_all), 32'd1);
      end
      check_eq($sformatf("%s_busy%0d", tag, i), 32'(b_all), 32'd1);
    end
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(4 * HALF);
    check_eq({tag, "_oe_idle"}, 32'(spi_miso_oe), 32'd0);
    check_eq({tag, "_miso_idle"}, 32'(spi_miso), 32'd0);
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    if (wr) begin
      check_eq({tag, "_we_cnt"}, 32'(we_a_q.size()), 32'(n));
      check_eq({tag, "_re_cnt"}, 32'(re_a_q.size()), 32'd0);
      for (int i = 0; i < n && i < we_a_q.size(); i++) begin
        ea = 7'((int'(a) + i) % 128);
        check_eq($sformatf("%s_we_addr%0d", tag, i), 32'(we_a_q[i]), 32'(ea));
        check_eq($sformatf("%s_we_data%0d", tag, i), 32'(we_d_q[i]), 32'(tx_dat[i]));
      end
    end else begin
      check_eq({tag, "_re_cnt"}, 32'(re_a_q.size()), 32'(n + 1));
      check_eq({tag, "_we_cnt"}, 32'(we_a_q.size()), 32'd0);
      for (int i = 0; i <= n && i < re_a_q.size(); i++) begin
        ea = 7'((int'(a) + i) % 128);
        check_eq($sformatf("%s_re_addr%0d", tag, i), 32'(re_a_q[i]), 32'(ea));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_miso"}, 32'(spi_miso), 32'd0);
    check_eq({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    check_eq({tag, "_addr"}, 32'(reg_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    check_eq({tag, "_we"}, 32'(reg_we), 32'd0);
    check_eq({tag, "_re"}, 32'(reg_re), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    bit oe_any, oe_all, b_all;
    bit wr;
    int n;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h12] = 8'h3C;
    for (int i = 8'h20; i <= 8'h22; i++) mem[i] = 8'(i) ^ 8'hFF;

    rstn     = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_cyc(3);
    check_all_zero("rst");
    rstn = 1'b1;
    wait_cyc(8);
    check_eq("idle_busy", 32'(busy), 32'd0);

    tx_dat[0] = 8'hA5;
    do_xfer(1'b1, 7'h05, 1, "wr05");
    do_xfer(1'b0, 7'h12, 1, "rd12");
    tx_dat[0] = 8'h11;
    tx_dat[1] = 8'h22;
    do_xfer(1'b1, 7'h7F, 2, "wrwrap");
    do_xfer(1'b0, 7'h20, 2, "rdburst");

    // Deselect after half a data frame: nothing may be written.
    clear_logs();
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    spi_shift(8'h83, 8, rx, oe_any, oe_all, b_all);
    spi_shift(8'hF0, 4, rx, oe_any, oe_all, b_all);
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(4 * HALF);
    check_eq("partial_we_cnt", 32'(we_a_q.size()), 32'd0);
    tx_dat[0] = 8'h77;
    do_xfer(1'b1, 7'h03, 1, "wr03");

    // Reset in the middle of a read data frame with cs held low.
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    spi_shift(8'h12, 8, rx, oe_any, oe_all, b_all);
    spi_shift(8'h00, 3, rx, oe_any, oe_all, b_all);
    check_eq("pre_rst_oe", 32'(spi_miso_oe), 32'd1);
    #2 rstn = 1'b0;
    #1 check_all_zero("midrst");
    wait_cyc(3);
    rstn = 1'b1;
    wait_cyc(2);
    clear_logs();
    spi_shift(8'h85, 8, rx, oe_any, oe_all, b_all);
    spi_shift(8'hA5, 8, rx, oe_all, oe_all, b_all);
    wait_cyc(2 * HALF);
    check_eq("postrst_we_cnt", 32'(we_a_q.size()), 32'd0);
    check_eq("postrst_re_cnt", 32'(re_a_q.size()), 32'd0);
    check_eq("postrst_oe", 32'(spi_miso_oe), 32'd0);
    spi_cs_n = 1'b1;
    wait_cyc(4 * HALF);
    tx_dat[0] = 8'h5A;
    do_xfer(1'b1, 7'h01, 1, "wr01");

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom);
      n  = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) tx_dat[i] = 8'($urandom);
      do_xfer(wr, 7'($urandom), n, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
